intrusion_monitor: RTL and testbench

Per-router intrusion detector that produces the 2-bit intrusion code consumed by the secure core, one instance per mesh node (0..15). It snoops the router's local injection port, detects flooding, unauthorized-destination and malformed-packet events, and reports the highest-priority event. It holds the code stable until the secure core acknowledges through that node's `sc_out_N` bit, then clears and reports any pending event.

---
 rtl/noc_sec_pkg.sv | 44 ++++
 rtl/flood_rate_counter.sv | 63 ++++++
 rtl/intrusion_monitor.sv | 165 ++++++++++++++++
 tb/tb_intrusion_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_sec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_sec_pkg
// Description : Shared definitions for the NoC intrusion monitor: intrusion
//               codes, flit type encodings, flit field positions, monitor FSM
//               state encoding and a code-priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_sec_pkg;

    // Intrusion codes; a numerically larger code has higher priority.
    localparam logic [1:0] INTR_NONE   = 2'b00;
    localparam logic [1:0] INTR_FLOOD  = 2'b01;
    localparam logic [1:0] INTR_UNAUTH = 2'b10;
    localparam logic [1:0] INTR_MALF   = 2'b11;

    // Flit type field encodings
    localparam logic [1:0] FLIT_INV  = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    // Flit field bit positions
    localparam int TYPE_HI = 31;
    localparam int TYPE_LO = 30;
    localparam int SRC_HI  = 29;
    localparam int SRC_LO  = 26;
    localparam int DST_HI  = 25;
    localparam int DST_LO  = 22;

    // Reporting FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REPORT = 2'd1,
        ST_CLEAR  = 2'd2
    } mon_state_t;

    // Higher-priority of two intrusion codes
    function automatic logic [1:0] intr_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flood_rate_counter.sv
`default_nettype none
// ============================================================================
// Module      : flood_rate_counter
// Description : Counts head flits in a free-running observation window and
//               flags the first head that exceeds FLOOD_MAX in that window.
// Ports       : clk     - clock
//               rst     - asynchronous active-low reset
//               i_head  - strobe: a head flit was observed this cycle
//               o_flood - single-cycle pulse, aligned with the offending head
// Revision    : 1.0 - initial release
// ============================================================================
module flood_rate_counter #(
    parameter int WINDOW    = 64,
    parameter int FLOOD_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_head,
    output logic o_flood
);

    localparam int c_win_w = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int c_cnt_w = $clog2(FLOOD_MAX + 2);

    localparam logic [c_win_w-1:0] c_win_last  = c_win_w'(WINDOW - 1);
    localparam logic [c_cnt_w-1:0] c_flood_max = c_cnt_w'(FLOOD_MAX);
    localparam logic [c_cnt_w-1:0] c_cnt_sat   = c_cnt_w'(FLOOD_MAX + 1);

    logic [c_win_w-1:0] r_win;
    logic [c_cnt_w-1:0] r_heads;
    logic               r_fired;
    logic               w_wrap;

    assign w_wrap = (r_win == c_win_last);

    // A head in the wrap cycle belongs to the next window as its first head,
    // so it can never be the offending one (FLOOD_MAX >= 1).
    assign o_flood = i_head && !w_wrap && !r_fired && (r_heads == c_flood_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win   <= '0;
            r_heads <= '0;
            r_fired <= 1'b0;
        end else begin
            r_win <= w_wrap ? '0 : r_win + 1'b1;
            if (w_wrap) begin
                r_heads <= i_head ? c_cnt_w'(1) : '0;
                r_fired <= 1'b0;
            end else begin
                // Saturate once past the limit; only the first excess matters.
                if (i_head && (r_heads != c_cnt_sat)) begin
                    r_heads <= r_heads + 1'b1;
                end
                if (o_flood) begin
                    r_fired <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intrusion_monitor.sv
`default_nettype none
// ============================================================================
// Module      : intrusion_monitor
// Description : Per-router intrusion detector. Snoops the local injection
//               port for flooding, unauthorized-destination and malformed
//               packets, and reports the highest-priority code to the secure
//               core, holding it until acknowledged.
// Ports       : clk        - clock
//               rst        - asynchronous active-low reset
//               flit_in    - snooped flit ([31:30] type, [29:26] src, [25:22] dst)
//               flit_valid - injection-port valid
//               flit_ready - injection-port ready
//               sc_ack     - acknowledge from the secure core
//               intrusion  - registered intrusion code
//               pending    - a further event is queued behind the current one
//               event_cnt  - saturating count of detected events
// Revision    : 1.0 - initial release
// ============================================================================
module intrusion_monitor
    import noc_sec_pkg::*;
#(
    parameter int          NODE_ID    = 0,
    parameter int          FLIT_W     = 32,
    parameter int          WINDOW     = 64,
    parameter int          FLOOD_MAX  = 16,
    parameter logic [15:0] PROT_MASK  = 16'h8000,
    parameter logic [15:0] ALLOW_MASK = 16'h0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid,
    input  logic              flit_ready,
    input  logic              sc_ack,
    output logic [1:0]        intrusion,
    output logic              pending,
    output logic [7:0]        event_cnt
);

    localparam logic [3:0] c_node = 4'(NODE_ID);

    logic       w_obs;
    logic [1:0] w_type;
    logic [3:0] w_src;
    logic [3:0] w_dst;
    logic       w_head;
    logic       w_tail;
    logic       w_malf;
    logic       w_unauth;
    logic       w_flood;
    logic       w_event;
    logic [1:0] w_code;
    logic [1:0] w_pend_merged;
    logic       w_unused_bits;

    logic       r_pkt_open;
    logic [1:0] r_pend_code;
    mon_state_t r_state;

    // Payload bits beyond the decoded header fields are not inspected.
    assign w_unused_bits = ^flit_in;

    assign w_obs  = flit_valid && flit_ready;
    assign w_type = flit_in[TYPE_HI:TYPE_LO];
    assign w_src  = flit_in[SRC_HI:SRC_LO];
    assign w_dst  = flit_in[DST_HI:DST_LO];
    assign w_head = w_obs && (w_type == FLIT_HEAD);
    assign w_tail = w_obs && (w_type == FLIT_TAIL);

    assign w_malf = w_obs && (
                        (((w_type == FLIT_BODY) || (w_type == FLIT_TAIL)) && !r_pkt_open) ||
                        ((w_type == FLIT_HEAD) && r_pkt_open) ||
                        (w_type == FLIT_INV) ||
                        ((w_type == FLIT_HEAD) && (w_src != c_node)));

    assign w_unauth = w_head && PROT_MASK[w_dst] && !ALLOW_MASK[w_src];

    flood_rate_counter #(
        .WINDOW    (WINDOW),
        .FLOOD_MAX (FLOOD_MAX)
    ) u_flood (
        .clk     (clk),
        .rst     (rst),
        .i_head  (w_head),
        .o_flood (w_flood)
    );

    // Simultaneous detections collapse into one event carrying the top code.
    assign w_event = w_malf || w_unauth || w_flood;
    assign w_code  = w_malf   ? INTR_MALF   :
                     w_unauth ? INTR_UNAUTH :
                     w_flood  ? INTR_FLOOD  : INTR_NONE;

    assign w_pend_merged = intr_max(r_pend_code, w_code);

    // Any head opens a packet, even a malformed one; only a tail closes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_open <= 1'b0;
        end else if (w_head) begin
            r_pkt_open <= 1'b1;
        end else if (w_tail) begin
            r_pkt_open <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            event_cnt <= 8'd0;
        end else if (w_event && (event_cnt != 8'hFF)) begin
            event_cnt <= event_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            intrusion   <= INTR_NONE;
            pending     <= 1'b0;
            r_pend_code <= INTR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        r_state   <= ST_REPORT;
                        intrusion <= w_code;
                    end
                end
                ST_REPORT: begin
                    if (w_event) begin
                        r_pend_code <= w_pend_merged;
                        pending     <= 1'b1;
                    end
                    if (sc_ack) begin
                        r_state   <= ST_CLEAR;
                        intrusion <= INTR_NONE;
                    end
                end
                ST_CLEAR: begin
                    // Code stays 00 here for at least one cycle, giving the
                    // secure core a clean edge before any queued report.
                    if (!sc_ack) begin
                        if (pending || w_event) begin
                            r_state     <= ST_REPORT;
                            intrusion   <= w_pend_merged;
                            pending     <= 1'b0;
                            r_pend_code <= INTR_NONE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_event) begin
                        r_pend_code <= w_pend_merged;
                        pending     <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    intrusion <= INTR_NONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intrusion_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_intrusion_monitor
// Description : Scoreboard bench for intrusion_monitor. Each driven cycle
//               pushes the expected outputs; they are popped and compared
//               one cycle later against the registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intrusion_monitor;

    localparam logic [1:0] T_INV  = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef struct {
        logic [1:0] intr;
        logic       pend;
        logic [7:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] flit_in;
    logic        flit_valid;
    logic        flit_ready;
    logic        sc_ack;
    logic [1:0]  intrusion;
    logic        pending;
    logic [7:0]  event_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_cnt  = 0;
    int    cyc      = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    intrusion_monitor #(
        .NODE_ID    (0),
        .FLIT_W     (32),
        .WINDOW     (64),
        .FLOOD_MAX  (16),
        .PROT_MASK  (16'h8000),
        .ALLOW_MASK (16'h0002)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .sc_ack     (sc_ack),
        .intrusion  (intrusion),
        .pending    (pending),
        .event_cnt  (event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the edge,
    // then compare them once the edge has happened.
    task automatic step(input string tag, input logic [1:0] ty, input logic [3:0] src,
                        input logic [3:0] dst, input logic vld, input logic rdy,
                        input logic ack, input bit ev, input logic [1:0] e_intr,
                        input logic e_pend);
        exp_t  e;
        string t;
        flit_in    = {ty, src, dst, 22'h0};
        flit_valid = vld;
        flit_ready = rdy;
        sc_ack     = ack;
        if (ev && exp_cnt < 255) exp_cnt++;
        exp_q.push_back('{e_intr, e_pend, 8'(exp_cnt)});
        tag_q.push_back(tag);
        @(posedge clk);
        cyc++;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".intr"}, 32'(intrusion), 32'(e.intr));
        check({t, ".pend"}, 32'(pending),   32'(e.pend));
        check({t, ".cnt"},  32'(event_cnt), 32'(e.cnt));
    endtask

    task automatic idle(input string tag, input int n, input logic [1:0] e_intr, input logic e_pend);
        for (int i = 0; i < n; i++) step(tag, T_INV, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, e_intr, e_pend);
    endtask

    // Legal head/tail packets that must not raise anything.
    task automatic pkts(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, T_HEAD, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
            step(tag, T_TAIL, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        end
    endtask

    task automatic ack_release(input string tag);
        step({tag, "_ack"}, T_INV, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        step({tag, "_rel"}, T_INV, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic wait_phase(input int p);
        int guard;
        guard = 0;
        while ((cyc % 64) != p && guard < 64) begin
            idle("align", 1, 2'b00, 1'b0);
            guard++;
        end
    endtask

    initial begin
        rst        = 1'b0;
        flit_in    = 32'h0;
        flit_valid = 1'b0;
        flit_ready = 1'b1;
        sc_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.intr", 32'(intrusion), 32'h0);
        check("reset.pend", 32'(pending),   32'h0);
        check("reset.cnt",  32'(event_cnt), 32'h0);
        rst = 1'b1;
        cyc = 0;

        // Legal packet and non-handshaked flits raise nothing
        step("legal_head", T_HEAD, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("legal_body", T_BODY, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("legal_tail", T_TAIL, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("noready",    T_BODY, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("novalid",    T_BODY, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        idle("legal_idle", 2, 2'b00, 1'b0);

        // Orphan body: malformed, held until acknowledged
        step("orphan_body", T_BODY, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        idle("malf_hold", 10, 2'b11, 1'b0);
        ack_release("malf");
        idle("malf_idle", 1, 2'b00, 1'b0);

        // Unauthorized access to protected node 15 from non-allowed src 0
        step("unauth",      T_HEAD, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        step("unauth_tail", T_TAIL, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        ack_release("unauth");

        // Head while open to a protected node: one combined event, code 11
        step("comb_head1", T_HEAD, 4'd0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("comb_head2", T_HEAD, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        step("comb_tail",  T_TAIL, 4'd0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        ack_release("comb");

        // Head from a foreign source, then an invalid-type flit
        step("badsrc",      T_HEAD, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        step("badsrc_tail", T_TAIL, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        ack_release("badsrc");
        step("invtype", T_INV, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        ack_release("invtype");

        // Flood: 17 heads in one window, then pending malformed behind it
        wait_phase(0);
        for (int i = 0; i < 17; i++) begin
            step("flood_head", T_HEAD, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, (i == 16),
                 (i == 16) ? 2'b01 : 2'b00, 1'b0);
            step("flood_tail", T_TAIL, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0,
                 (i == 16) ? 2'b01 : 2'b00, 1'b0);
        end
        step("pend_malf", T_BODY, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
        step("pend_ack1", T_INV, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        step("pend_ack2", T_INV, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        step("pend_show", T_INV, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        ack_release("pend");
        pkts("flood_once", 2);

        // Exactly FLOOD_MAX heads in a window: no report
        wait_phase(0);
        pkts("flood16", 16);

        // Head in the wrap cycle counts as the first head of the new window
        wait_phase(0);
        pkts("wrap_pre", 15);
        wait_phase(61);
        step("wrap_h16",  T_HEAD, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("wrap_t16",  T_TAIL, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("wrap_head", T_HEAD, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("wrap_tail", T_TAIL, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        pkts("wrap_post", 15);
        step("wrap_h17", T_HEAD, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        step("wrap_t17", T_TAIL, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        ack_release("wrap");

        // Asynchronous reset in the middle of a report
        step("rst_ev1", T_BODY, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        step("rst_ev2", T_BODY, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst.intr", 32'(intrusion), 32'h0);
        check("midrst.pend", 32'(pending),   32'h0);
        check("midrst.cnt",  32'(event_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        cyc     = 0;
        exp_cnt = 0;

        // 300 consecutive malformed flits: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            step("sat", T_BODY, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, (i > 0));
        end
        check("sat_final", 32'(event_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
